alu_op_sequencer: RTL and testbench

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_cmd_fifo.sv | 49 ++++
 rtl/alu_op_sequencer.sv | 113 +++++++++++
 tb/tb_alu_op_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, FSM encoding and command metadata for the ALU op sequencer.
package alu_pkg;

  localparam int OP_W  = 4;
  localparam int SH_W  = 5;
  localparam int TAG_W = 4;

  localparam logic [OP_W-1:0] OP_ROL       = 4'd0;
  localparam logic [OP_W-1:0] OP_ROR       = 4'd1;
  localparam logic [OP_W-1:0] OP_MAX       = 4'd2;
  localparam logic [OP_W-1:0] OP_MIN       = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR       = 4'd4;
  localparam logic [OP_W-1:0] OP_MAX_LEGAL = 4'd4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  typedef struct packed {
    logic [OP_W-1:0]  opcode;
    logic [SH_W-1:0]  shift;
    logic [TAG_W-1:0] tag;
  } cmd_meta_t;

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return op <= OP_MAX_LEGAL;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO; power-of-two depth so pointers wrap by natural overflow.
module alu_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Queues ALU commands, drives a combinational ALU for SETTLE cycles, returns tagged results.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [OP_W-1:0]          cmd_opcode,
  input  logic [WIDTH-1:0]         cmd_a,
  input  logic [WIDTH-1:0]         cmd_b,
  input  logic [SH_W-1:0]          cmd_shift,
  input  logic [TAG_W-1:0]         cmd_tag,
  output logic [OP_W-1:0]          alu_opcode,
  output logic [WIDTH-1:0]         alu_input1,
  output logic [WIDTH-1:0]         alu_input2,
  output logic [SH_W-1:0]          alu_shiftValue,
  input  logic [WIDTH-1:0]         alu_result,
  input  logic                     alu_carry,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_carry,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic                     rsp_illegal,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    cmd_meta_t        meta;
  } cmd_t;

  cmd_t              wr, rd;
  logic              full, empty, push, pop;
  logic [1:0]        state;
  logic [TAG_W-1:0]  cur_tag;
  logic [SETTLE-1:0] vld_pipe;

  assign wr        = {cmd_a, cmd_b, cmd_opcode, cmd_shift, cmd_tag};
  assign cmd_ready = ~full;
  assign push      = cmd_valid & cmd_ready;
  assign pop       = (state == ST_IDLE) & ~empty;
  assign rsp_valid = (state == ST_RESP);
  assign busy      = (state != ST_IDLE);

  alu_cmd_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wr),
    .pop   (pop),
    .rdata (rd),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      vld_pipe       <= '0;
      cur_tag        <= '0;
      alu_opcode     <= '0;
      alu_input1     <= '0;
      alu_input2     <= '0;
      alu_shiftValue <= '0;
      rsp_result     <= '0;
      rsp_carry      <= 1'b0;
      rsp_tag        <= '0;
      rsp_illegal    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (pop) begin
          cur_tag <= rd.meta.tag;
          if (op_legal(rd.meta.opcode)) begin
            alu_opcode     <= rd.meta.opcode;
            alu_input1     <= rd.a;
            alu_input2     <= rd.b;
            alu_shiftValue <= rd.meta.shift;
            vld_pipe       <= SETTLE'(1);
            state          <= ST_DRIVE;
          end else begin
            // Illegal opcodes never touch the ALU; answer straight away.
            rsp_result  <= '0;
            rsp_carry   <= 1'b0;
            rsp_tag     <= rd.meta.tag;
            rsp_illegal <= 1'b1;
            state       <= ST_RESP;
          end
        end
        ST_DRIVE: begin
          vld_pipe <= vld_pipe << 1;
          if (vld_pipe[SETTLE-1]) begin
            rsp_result  <= alu_result;
            rsp_carry   <= alu_carry;
            rsp_tag     <= cur_tag;
            rsp_illegal <= 1'b0;
            state       <= ST_RESP;
          end
        end
        ST_RESP: if (rsp_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU attached.
module tb_alu_op_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_opcode;
  logic [63:0] cmd_a, cmd_b;
  logic [4:0]  cmd_shift;
  logic [3:0]  cmd_tag;
  logic [3:0]  alu_opcode;
  logic [63:0] alu_input1, alu_input2;
  logic [4:0]  alu_shiftValue;
  logic [63:0] alu_result;
  logic        alu_carry;
  logic        rsp_valid, rsp_ready;
  logic [63:0] rsp_result;
  logic        rsp_carry;
  logic [3:0]  rsp_tag;
  logic        rsp_illegal;
  logic        busy;
  logic [2:0]  count;

  int n_checks = 0;
  int n_err    = 0;

  logic [63:0] q_res[$];
  logic [3:0]  q_tag[$];
  logic        q_ill[$];

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(64), .DEPTH(4), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_shift(cmd_shift), .cmd_tag(cmd_tag),
    .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
    .alu_shiftValue(alu_shiftValue), .alu_result(alu_result), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_tag(rsp_tag),
    .rsp_illegal(rsp_illegal), .busy(busy), .count(count)
  );

  // Reference ALU: carry flags input1 > input2 (unsigned).
  always_comb begin
    alu_result = '0;
    case (alu_opcode)
      4'd0: alu_result = (alu_input1 << alu_shiftValue) | (alu_input1 >> (7'd64 - {2'b0, alu_shiftValue}));
      4'd1: alu_result = (alu_input1 >> alu_shiftValue) | (alu_input1 << (7'd64 - {2'b0, alu_shiftValue}));
      4'd2: alu_result = (alu_input1 > alu_input2) ? alu_input1 : alu_input2;
      4'd3: alu_result = (alu_input1 < alu_input2) ? alu_input1 : alu_input2;
      4'd4: alu_result = alu_input1 ^ alu_input2;
      default: alu_result = '0;
    endcase
    alu_carry = (alu_input1 > alu_input2);
  end

  always @(posedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      q_res.push_back(rsp_result);
      q_tag.push_back(rsp_tag);
      q_ill.push_back(rsp_illegal);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_res.delete();
    q_tag.delete();
    q_ill.delete();
  endtask

  task automatic send(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                      input logic [4:0] sh, input logic [3:0] tag);
    cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_shift = sh; cmd_tag = tag;
    for (int i = 0; i < 50 && !cmd_ready; i++) tick();
    if (!cmd_ready) chk("send_timeout", 64'd0, 64'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    for (int i = 0; i < 200 && q_res.size() < n; i++) tick();
    chk("rsp_count", 64'(q_res.size()), 64'(n));
  endtask

  initial begin
    logic [63:0] exp_r;
    int          held;
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_opcode = '0; cmd_a = '0; cmd_b = '0; cmd_shift = '0; cmd_tag = '0;
    #3;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_count",     64'(count),     64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_alu_in1",   alu_input1,     64'd0);
    chk("rst_rsp_res",   rsp_result,     64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // XOR latency: accepted on first edge after release, response two edges later
    send(4'd4, 64'hFF00, 64'h0FF0, 5'd0, 4'd3);
    chk("xor_cnt_after_acc", 64'(count), 64'd1);
    chk("xor_vld_e0", 64'(rsp_valid), 64'd0);
    tick();
    chk("xor_vld_e1",  64'(rsp_valid), 64'd0);
    chk("xor_busy_e1", 64'(busy), 64'd1);
    chk("xor_aluop",   64'(alu_opcode), 64'd4);
    tick();
    chk("xor_vld_e2",  64'(rsp_valid), 64'd1);
    chk("xor_result",  rsp_result, 64'hF0F0);
    chk("xor_carry",   64'(rsp_carry), 64'd1);
    chk("xor_tag",     64'(rsp_tag), 64'd3);
    chk("xor_illegal", 64'(rsp_illegal), 64'd0);
    rsp_ready = 1'b1;
    tick();
    chk("xor_done_vld", 64'(rsp_valid), 64'd0);
    clear_q();

    // ROL then MAX back-to-back
    send(4'd0, 64'd1, 64'd0, 5'd4, 4'd1);
    send(4'd2, 64'd5, 64'd7, 5'd0, 4'd2);
    wait_rsp(2);
    if (q_res.size() >= 2) begin
      chk("rol_res", q_res[0], 64'h10);
      chk("rol_tag", 64'(q_tag[0]), 64'd1);
      chk("max_res", q_res[1], 64'd7);
      chk("max_tag", 64'(q_tag[1]), 64'd2);
    end
    tick();

    // Illegal opcode: one-edge response, ALU registers untouched (still MAX 5,7)
    rsp_ready = 1'b0;
    clear_q();
    send(4'd9, 64'hDEAD, 64'hBEEF, 5'd3, 4'd5);
    chk("ill_vld_e0", 64'(rsp_valid), 64'd0);
    tick();
    chk("ill_vld_e1",  64'(rsp_valid), 64'd1);
    chk("ill_flag",    64'(rsp_illegal), 64'd1);
    chk("ill_result",  rsp_result, 64'd0);
    chk("ill_carry",   64'(rsp_carry), 64'd0);
    chk("ill_tag",     64'(rsp_tag), 64'd5);
    chk("ill_aluop",   64'(alu_opcode), 64'd2);
    chk("ill_alu_in1", alu_input1, 64'd5);
    chk("ill_alu_in2", alu_input2, 64'd7);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("ill_q", 64'(q_ill.size()), 64'd1);

    // Backpressure: 6 offered, 5 accepted
    clear_q();
    for (int i = 0; i < 5; i++) send(4'd4, 64'(i), 64'h100, 5'd0, 4'(i));
    cmd_valid = 1'b1; cmd_opcode = 4'd4; cmd_a = 64'd5; cmd_b = 64'h100; cmd_tag = 4'd5;
    repeat (3) tick();
    chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("bp_count",     64'(count), 64'd4);
    chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("bp_tag",       64'(rsp_tag), 64'd0);
    chk("bp_res",       rsp_result, 64'h100);
    tick();
    chk("bp_tag_stable", 64'(rsp_tag), 64'd0);
    chk("bp_res_stable", rsp_result, 64'h100);
    rsp_ready = 1'b1;
    for (int i = 0; i < 50 && !cmd_ready; i++) tick();
    chk("bp_space_freed", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
    wait_rsp(6);
    for (int i = 0; i < 6 && i < q_res.size(); i++) begin
      chk($sformatf("bp_order_tag%0d", i), 64'(q_tag[i]), 64'(i));
      chk($sformatf("bp_order_res%0d", i), q_res[i], 64'h100 | 64'(i));
    end
    tick();

    // count=3 with simultaneous push/pop; 10 commands wrap the pointers
    rsp_ready = 1'b0;
    clear_q();
    for (int k = 0; k < 4; k++) send(4'd3, 64'(k), 64'd3, 5'd0, 4'(k));
    chk("pp_count_fill", 64'(count), 64'd3);
    rsp_ready = 1'b1;
    for (int k = 4; k < 10; k++) begin
      for (int i = 0; i < 20 && busy; i++) tick();
      chk("pp_idle", 64'(busy), 64'd0);
      cmd_valid = 1'b1; cmd_opcode = 4'd3; cmd_a = 64'(k); cmd_b = 64'd3; cmd_tag = 4'(k);
      tick();
      cmd_valid = 1'b0;
      chk($sformatf("pp_count_k%0d", k), 64'(count), 64'd3);
    end
    wait_rsp(10);
    for (int k = 0; k < 10 && k < q_res.size(); k++) begin
      exp_r = (k < 3) ? 64'(k) : 64'd3;
      chk($sformatf("pp_tag%0d", k), 64'(q_tag[k]), 64'(k));
      chk($sformatf("pp_res%0d", k), q_res[k], exp_r);
    end
    tick();

    // Reset during DRIVE with two queued
    rsp_ready = 1'b0;
    clear_q();
    for (int k = 0; k < 4; k++) send(4'd4, 64'h11, 64'(k), 5'd0, 4'(10 + k));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick();
    chk("rd_busy",  64'(busy), 64'd1);
    chk("rd_count", 64'(count), 64'd2);
    chk("rd_aluop", 64'(alu_opcode), 64'd4);
    held = q_res.size();
    chk("rd_first_rsp", 64'(held), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rd_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rd_count0",    64'(count), 64'd0);
    chk("rd_alu_op0",   64'(alu_opcode), 64'd0);
    chk("rd_alu_in1",   alu_input1, 64'd0);
    chk("rd_alu_in2",   alu_input2, 64'd0);
    chk("rd_busy0",     64'(busy), 64'd0);
    chk("rd_cmd_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk) rst_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (10) tick();
    chk("rd_no_stale_vld", 64'(rsp_valid), 64'd0);
    chk("rd_no_stale_q",   64'(q_res.size()), 64'(held));
    chk("rd_count_after",  64'(count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
